// File: rtl/mux_sync_pkg.sv
// mux_sync_pkg: shared types and defaults for the mux-feedback synchronizer sender.
package mux_sync_pkg;
    localparam int DEFAULT_DWIDTH = 32;
    typedef enum logic [1:0] {IDLE, REQ, ACK_WAIT} tx_state_t;
endpackage

// File: rtl/mux_sync_tx_if.sv
// mux_sync_tx_if: producer, synchronizer handshake and status signals of mux_sync_tx.
interface mux_sync_tx_if
    import mux_sync_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);
    logic [DWIDTH-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic [DWIDTH-1:0] o_sync_data;
    logic              o_sync_valid;
    logic              i_sync_ready;
    logic              o_done;
    logic              o_busy;
    logic [AW:0]       o_level;
    modport slave (
        input  i_data, i_valid, i_sync_ready,
        output o_ready, o_sync_data, o_sync_valid, o_done, o_busy, o_level
    );
    modport master (
        output i_data, i_valid, i_sync_ready,
        input  o_ready, o_sync_data, o_sync_valid, o_done, o_busy, o_level
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; a push while full is dropped even if a pop coincides.
module sync_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              do_push, do_pop;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk)
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= do_push ? wptr + 1'b1 : wptr;
            rptr  <= do_pop ? rptr + 1'b1 : rptr;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/mux_sync_tx.sv
// mux_sync_tx: buffers producer words and sends them one at a time over a four-phase
// handshake against the already-synchronized ready feedback; data is frozen outside IDLE->REQ.
module mux_sync_tx
    import mux_sync_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH,
    parameter int DEPTH  = 4
) (
    input logic           i_src_clk,
    input logic           rst,
    mux_sync_tx_if.slave  bus
);
    tx_state_t         state;
    logic [DWIDTH-1:0] head;
    logic              full, empty, pop;
    // a ready still high in IDLE is a stale ack, so never start until it has fallen
    assign pop        = (state == IDLE) & ~empty & ~bus.i_sync_ready;
    assign bus.o_ready = ~full;
    assign bus.o_busy  = (state != IDLE) | ~empty;
    sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) fifo (
        .clk(i_src_clk),
        .rst(rst),
        .push(bus.i_valid),
        .pop(pop),
        .wdata(bus.i_data),
        .rdata(head),
        .full(full),
        .empty(empty),
        .level(bus.o_level)
    );
    always_ff @(posedge i_src_clk)
        if (rst) begin
            state            <= IDLE;
            bus.o_sync_data  <= '0;
            bus.o_sync_valid <= 1'b0;
            bus.o_done       <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE:
                    if (pop) begin
                        bus.o_sync_data  <= head;
                        bus.o_sync_valid <= 1'b1;
                        state            <= REQ;
                    end
                REQ:
                    if (bus.i_sync_ready) begin
                        bus.o_sync_valid <= 1'b0;
                        state            <= ACK_WAIT;
                    end
                ACK_WAIT:
                    if (!bus.i_sync_ready) begin
                        bus.o_done <= 1'b1;
                        state      <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mux_sync_tx.sv
// tb_mux_sync_tx: directed scenarios for mux_sync_tx with hand-computed expectations.
module tb_mux_sync_tx;
    localparam int DW = 32;
    localparam int DP = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    mux_sync_tx_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();
    mux_sync_tx #(.DWIDTH(DW), .DEPTH(DP)) dut (.i_src_clk(clk), .rst(rst), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        tick;
        bus.i_valid = 1'b0;
    endtask

    // auto-responder: ready rises 3 cycles after valid, falls 3 cycles after valid drops
    task automatic xfer(input logic [31:0] exp, input string nm);
        int t = 0;
        while (!bus.o_sync_valid && t < 40) begin tick; t++; end
        n_cmp++; if (bus.o_sync_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid_timeout: got %0b want 1", nm, bus.o_sync_valid); end
        n_cmp++; if (bus.o_sync_data !== exp) begin n_err++; $display("FAIL %s_data: got %h want %h", nm, bus.o_sync_data, exp); end
        repeat (2) begin
            tick;
            n_cmp++; if (bus.o_sync_data !== exp || bus.o_sync_valid !== 1'b1) begin n_err++; $display("FAIL %s_req_hold: got %h/%0b want %h/1", nm, bus.o_sync_data, bus.o_sync_valid, exp); end
        end
        bus.i_sync_ready = 1'b1;
        tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b0 || bus.o_sync_data !== exp) begin n_err++; $display("FAIL %s_ack: got %h/%0b want %h/0", nm, bus.o_sync_data, bus.o_sync_valid, exp); end
        repeat (2) begin
            tick;
            n_cmp++; if (bus.o_sync_data !== exp || bus.o_done !== 1'b0) begin n_err++; $display("FAIL %s_ack_hold: got %h/done %0b want %h/0", nm, bus.o_sync_data, bus.o_done, exp); end
        end
        bus.i_sync_ready = 1'b0;
        tick;
        n_cmp++; if (bus.o_done !== 1'b1 || bus.o_sync_data !== exp) begin n_err++; $display("FAIL %s_done: got done %0b data %h want 1 %h", nm, bus.o_done, bus.o_sync_data, exp); end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_sync_ready = 1'b0;
        tick; tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", bus.o_sync_valid); end
        n_cmp++; if (bus.o_sync_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", bus.o_sync_data); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b want 0", bus.o_done); end
        n_cmp++; if (bus.o_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", bus.o_level); end
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", bus.o_ready); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", bus.o_busy); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        bus.i_sync_ready = 1'b0;
        push_word(32'hA5A5_0001);
        n_cmp++; if (bus.o_level !== 3'd1 || bus.o_sync_valid !== 1'b0) begin n_err++; $display("FAIL single_push: got lvl %0d valid %0b want 1 0", bus.o_level, bus.o_sync_valid); end
        tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b1 || bus.o_sync_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_req: got %0b %h want 1 a5a50001", bus.o_sync_valid, bus.o_sync_data); end
        n_cmp++; if (bus.o_level !== 3'd0) begin n_err++; $display("FAIL single_pop_level: got %0d want 0", bus.o_level); end
        repeat (3) tick;
        bus.i_sync_ready = 1'b1;
        tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b0 || bus.o_sync_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_ack: got %0b %h want 0 a5a50001", bus.o_sync_valid, bus.o_sync_data); end
        bus.i_sync_ready = 1'b0;
        tick;
        n_cmp++; if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL single_done: got done %0b busy %0b want 1 0", bus.o_done, bus.o_busy); end
        tick;
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse: got %0b want 0", bus.o_done); end
    endtask

    task automatic test_full;
        bus.i_sync_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                n_cmp++; if (bus.o_ready !== 1'b0 || bus.o_level !== 3'd4) begin n_err++; $display("FAIL full_flag: got rdy %0b lvl %0d want 0 4", bus.o_ready, bus.o_level); end
            end
            bus.i_data  = 32'hF0 + 32'(k);
            bus.i_valid = 1'b1;
            tick;
        end
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.o_level !== 3'd4) begin n_err++; $display("FAIL full_ignored: got lvl %0d want 4", bus.o_level); end
        bus.i_sync_ready = 1'b0;
        tick;
        n_cmp++; if (bus.o_level !== 3'd3 || bus.o_ready !== 1'b1) begin n_err++; $display("FAIL full_release: got lvl %0d rdy %0b want 3 1", bus.o_level, bus.o_ready); end
        xfer(32'hF0, "full0");
        xfer(32'hF1, "full1");
        xfer(32'hF2, "full2");
        xfer(32'hF3, "full3");
        tick; tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL full_drop5: got valid %0b busy %0b want 0 0", bus.o_sync_valid, bus.o_busy); end
    endtask

    task automatic test_stream;
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    int  t = 0;
                    logic acc;
                    bus.i_data  = 32'(k);
                    bus.i_valid = 1'b1;
                    do begin acc = bus.o_ready; tick; t++; end while (!acc && t < 300);
                end
                bus.i_valid = 1'b0;
            end
            begin
                for (int k = 1; k <= 10; k++) xfer(32'(k), "stream");
            end
        join
        tick;
        n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_level !== 3'd0) begin n_err++; $display("FAIL stream_end: got busy %0b lvl %0d want 0 0", bus.o_busy, bus.o_level); end
    endtask

    task automatic test_stale;
        bus.i_sync_ready = 1'b1;
        push_word(32'hBEEF_0001);
        tick; tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b0 || bus.o_level !== 3'd1 || bus.o_busy !== 1'b1) begin n_err++; $display("FAIL stale_hold: got v %0b lvl %0d busy %0b want 0 1 1", bus.o_sync_valid, bus.o_level, bus.o_busy); end
        bus.i_sync_ready = 1'b0;
        tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b1 || bus.o_sync_data !== 32'hBEEF_0001) begin n_err++; $display("FAIL stale_release: got %0b %h want 1 beef0001", bus.o_sync_valid, bus.o_sync_data); end
        xfer(32'hBEEF_0001, "stale");
    endtask

    task automatic test_reset_mid;
        bus.i_sync_ready = 1'b0;
        push_word(32'hC1);
        push_word(32'hC2);
        push_word(32'hC3);
        n_cmp++; if (bus.o_level !== 3'd2 || bus.o_sync_valid !== 1'b1 || bus.o_sync_data !== 32'hC1) begin n_err++; $display("FAIL rmid_pre: got lvl %0d v %0b d %h want 2 1 c1", bus.o_level, bus.o_sync_valid, bus.o_sync_data); end
        rst = 1'b1;
        bus.i_sync_ready = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (bus.o_sync_valid !== 1'b0 || bus.o_level !== 3'd0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rmid_reset: got v %0b lvl %0d done %0b busy %0b want 0 0 0 0", bus.o_sync_valid, bus.o_level, bus.o_done, bus.o_busy); end
        push_word(32'hD1);
        tick; tick;
        n_cmp++; if (bus.o_sync_valid !== 1'b0 || bus.o_level !== 3'd1 || bus.o_done !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got v %0b lvl %0d done %0b want 0 1 0", bus.o_sync_valid, bus.o_level, bus.o_done); end
        bus.i_sync_ready = 1'b0;
        xfer(32'hD1, "rmid");
    endtask

    task automatic test_push_pop;
        bus.i_sync_ready = 1'b1;
        push_word(32'hE1);
        n_cmp++; if (bus.o_level !== 3'd1) begin n_err++; $display("FAIL pp_pre: got lvl %0d want 1", bus.o_level); end
        bus.i_sync_ready = 1'b0;
        bus.i_data  = 32'hE2;
        bus.i_valid = 1'b1;
        tick;
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.o_level !== 3'd1 || bus.o_sync_valid !== 1'b1 || bus.o_sync_data !== 32'hE1) begin n_err++; $display("FAIL pp_same_edge: got lvl %0d v %0b d %h want 1 1 e1", bus.o_level, bus.o_sync_valid, bus.o_sync_data); end
        xfer(32'hE1, "pp_first");
        xfer(32'hE2, "pp_second");
        tick;
        n_cmp++; if (bus.o_level !== 3'd0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL pp_end: got lvl %0d busy %0b want 0 0", bus.o_level, bus.o_busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_full;
        test_stream;
        test_stale;
        test_reset_mid;
        test_push_pop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
